// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and helpers
// for the instruction-fetch front end.
package fetch_pkg;

   localparam int FETCH_ADDR_W  = 64;
   localparam int FETCH_INSTR_W = 32;
   localparam int INSTR_BYTES   = FETCH_INSTR_W / 8;

   typedef enum logic {
      FETCH,
      STALL
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_INSTR_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0]  pc;
   } fetch_entry_t;

   // sign-extend the low w bits of field to 64 bits
   function automatic logic [63:0] sext_ofs(
      input logic [63:0] field,
      input int unsigned w
   );
      logic signed [63:0] t;
      t = $signed(field << (64 - w));
      return t >>> (64 - w);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction/PC buffer between fetch
// and decode with a registered head and sync clear.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  entry_t                     din_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output entry_t                     head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   entry_t           head_q, head_d;
   logic             do_push;
   logic             do_pop;

   // next pointers and count; head tracks the next front entry
   always_comb begin
      do_push = push_i && !clear_i;
      do_pop  = pop_i && !clear_i && (cnt_q != '0);
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      if (clear_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PTR_W'(1);
         if (do_pop)  rd_d = rd_q + PTR_W'(1);
         if (do_push && !do_pop)
            cnt_d = cnt_q + CNT_W'(1);
         else if (do_pop && !do_push)
            cnt_d = cnt_q - CNT_W'(1);
         if (cnt_d != '0) begin
            if (do_push && (wr_q == rd_d))
               head_d = din_i;
            else
               head_d = mem_q[rd_d];
         end
      end
   end

   // pointer, count and head registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   // storage, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   // a push into a full buffer means the credit check broke
   always @(posedge clk) begin
      if (!rst)
         assert (!(do_push && !do_pop && (cnt_q == CNT_W'(DEPTH))));
   end

   assign count_o = cnt_q;
   assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, credit-based request issue to a
// 1-cycle imem, and branch redirect handling.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              ADDR_W       = FETCH_ADDR_W,
   parameter int              INSTR_W      = FETCH_INSTR_W,
   parameter int              DEPTH        = 4,
   parameter int              UNCOND_OFS_W = 26,
   parameter int              COND_OFS_W   = 19,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [INSTR_W-1:0] inst_data,
   output logic [ADDR_W-1:0]  inst_pc,
   input  logic               redir_valid,
   input  logic               redir_uncond,
   input  logic [ADDR_W-1:0]  redir_pc,
   input  logic [INSTR_W-1:0] redir_instr
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;
   localparam int STEP  = (INSTR_W == FETCH_INSTR_W) ?
                          INSTR_BYTES : INSTR_W / 8;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              inflight_q;
   logic              issue;
   logic              credit;
   logic [SUM_W-1:0]  used;
   logic [CNT_W-1:0]  count;
   entry_t            entry_in;
   entry_t            head;
   logic              push;
   logic              pop;
   logic [63:0]       ofs_field;
   logic [63:0]       ofs_sext;
   logic [63:0]       ofs_shift;
   logic [ADDR_W-1:0] target;
   logic              unused_instr;

   assign used   = SUM_W'(count) + SUM_W'(inflight_q);
   assign credit = used < SUM_W'(DEPTH);

   // issue decision and FETCH/STALL tracking; redirect overrides
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         FETCH: begin
            if (credit) issue = 1'b1;
            else        state_d = STALL;
         end
         STALL: begin
            if (credit) begin
               issue   = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      if (redir_valid || rst) begin
         issue   = 1'b0;
         state_d = FETCH;
      end
   end

   // branch offset field selection and sign extension
   always_comb begin
      ofs_field = '0;
      ofs_sext  = '0;
      if (redir_uncond) begin
         ofs_field[UNCOND_OFS_W-1:0] = redir_instr[UNCOND_OFS_W-1:0];
         ofs_sext = sext_ofs(ofs_field, UNCOND_OFS_W);
      end else begin
         ofs_field[COND_OFS_W-1:0] = redir_instr[COND_OFS_W+4:5];
         ofs_sext = sext_ofs(ofs_field, COND_OFS_W);
      end
   end

   assign ofs_shift    = ofs_sext << 2;
   assign target       = redir_pc + ofs_shift[ADDR_W-1:0];
   assign unused_instr = ^redir_instr;

   // next PC: redirect target, sequential step, or hold
   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      if (redir_valid) begin
         pc_d = target;
      end else if (issue) begin
         pc_d     = pc_q + ADDR_W'(STEP);
         req_pc_d = pc_q;
      end
   end

   // state, PC and in-flight tracking registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= issue;
      end
   end

   assign push     = inflight_q && !redir_valid;
   assign pop      = inst_valid && inst_ready;
   assign entry_in = '{instr: imem_rdata, pc: req_pc_q};

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (entry_in),
      .pop_i   (pop),
      .clear_i (redir_valid),
      .count_o (count),
      .head_o  (head)
   );

   assign imem_req   = issue;
   assign imem_addr  = pc_q;
   assign inst_valid = (count != '0);
   assign inst_data  = head.instr;
   assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a
// queue-based reference model of the fetch front end.
module tb_fetch_unit;

   localparam int AW    = 64;
   localparam int IW    = 32;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          inst_valid;
   logic          inst_ready;
   logic [IW-1:0] inst_data;
   logic [AW-1:0] inst_pc;
   logic          redir_valid;
   logic          redir_uncond;
   logic [AW-1:0] redir_pc;
   logic [IW-1:0] redir_instr;

   logic          rst_w;
   logic          req_w;
   logic [AW-1:0] addr_w;
   logic [IW-1:0] rdata_w;
   logic          valid_w;
   logic [IW-1:0] data_w;
   logic [AW-1:0] pc_w;

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (64'h0)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst_data    (inst_data),
      .inst_pc      (inst_pc),
      .redir_valid  (redir_valid),
      .redir_uncond (redir_uncond),
      .redir_pc     (redir_pc),
      .redir_instr  (redir_instr)
   );

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
   ) u_wrap (
      .clk          (clk),
      .rst          (rst_w),
      .imem_req     (req_w),
      .imem_addr    (addr_w),
      .imem_rdata   (rdata_w),
      .inst_valid   (valid_w),
      .inst_ready   (1'b1),
      .inst_data    (data_w),
      .inst_pc      (pc_w),
      .redir_valid  (1'b0),
      .redir_uncond (1'b0),
      .redir_pc     ('0),
      .redir_instr  ('0)
   );

   // memory word k lives at byte address 4k
   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return a[33:2];
   endfunction

   always @(posedge clk) begin
      imem_rdata <= mem_word(imem_addr);
      rdata_w    <= mem_word(addr_w);
   end

   function automatic logic [AW-1:0] branch_target(
      input logic [AW-1:0] bpc,
      input logic          unc,
      input logic [IW-1:0] ins
   );
      logic signed [25:0] u;
      logic signed [18:0] c;
      longint             off;
      u   = ins[25:0];
      c   = ins[23:5];
      off = unc ? longint'(u) : longint'(c);
      return bpc + 64'(off * 4);
   endfunction

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
      end
   endtask

   // reference model: fetch queue plus one outstanding request
   typedef struct {
      logic [IW-1:0] d;
      logic [AW-1:0] p;
   } ent_t;

   ent_t          m_q[$];
   logic [AW-1:0] m_pc  = '0;
   logic          m_inf = 1'b0;
   logic [AW-1:0] m_ipc = '0;
   logic [IW-1:0] m_ld  = '0;
   logic [AW-1:0] m_lp  = '0;

   always @(negedge clk) begin
      logic          e_req;
      logic          e_val;
      logic [IW-1:0] e_d;
      logic [AW-1:0] e_p;
      if (rst) begin
         m_q.delete();
         m_pc  = '0;
         m_inf = 1'b0;
         m_ld  = '0;
         m_lp  = '0;
      end else begin
         e_req = !redir_valid && ((m_q.size() + int'(m_inf)) < DEPTH);
         e_val = m_q.size() > 0;
         e_d   = e_val ? m_q[0].d : m_ld;
         e_p   = e_val ? m_q[0].p : m_lp;
         chk("m_req",   imem_req,   e_req);
         chk("m_addr",  imem_addr,  m_pc);
         chk("m_valid", inst_valid, e_val);
         chk("m_data",  inst_data,  e_d);
         chk("m_pc",    inst_pc,    e_p);
         m_ld = e_d;
         m_lp = e_p;
         if (redir_valid) begin
            m_pc = branch_target(redir_pc, redir_uncond, redir_instr);
            m_q.delete();
            m_inf = 1'b0;
         end else begin
            if (inst_ready && e_val) void'(m_q.pop_front());
            if (m_inf) m_q.push_back('{d: mem_word(m_ipc), p: m_ipc});
            if (e_req) begin
               m_inf = 1'b1;
               m_ipc = m_pc;
               m_pc  = m_pc + 64'd4;
            end else begin
               m_inf = 1'b0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic unc, input logic [AW-1:0] bpc,
                        input logic [IW-1:0] ins);
      redir_valid  = 1'b1;
      redir_uncond = unc;
      redir_pc     = bpc;
      redir_instr  = ins;
   endtask

   initial begin
      rst          = 1'b1;
      rst_w        = 1'b1;
      inst_ready   = 1'b1;
      redir_valid  = 1'b0;
      redir_uncond = 1'b0;
      redir_pc     = '0;
      redir_instr  = '0;
      repeat (3) cyc();

      // sequential fetch from reset
      rst = 1'b0;
      #1;
      chk("seq_req0",  imem_req,   1);
      chk("seq_addr0", imem_addr,  0);
      chk("seq_val0",  inst_valid, 0);
      chk("seq_data0", inst_data,  0);
      cyc(); #1;
      chk("seq_addr1", imem_addr,  4);
      chk("seq_val1",  inst_valid, 0);
      cyc(); #1;
      chk("seq_val2",  inst_valid, 1);
      chk("seq_pc2",   inst_pc,    0);
      chk("seq_data2", inst_data,  0);
      chk("seq_addr2", imem_addr,  8);
      cyc(); #1;
      chk("seq_pc3",   inst_pc,    4);
      chk("seq_data3", inst_data,  1);
      chk("seq_addr3", imem_addr,  12);

      // back-pressure: fill to DEPTH, stall, then drain
      cyc();
      rst        = 1'b1;
      inst_ready = 1'b0;
      cyc();
      rst = 1'b0;
      repeat (9) cyc();
      #1;
      chk("bp_req",   imem_req,   0);
      chk("bp_valid", inst_valid, 1);
      chk("bp_pc",    inst_pc,    0);
      chk("bp_addr",  imem_addr,  16);
      cyc();
      inst_ready = 1'b1;
      #1;
      chk("bp_d0",    inst_data, 0);
      chk("bp_req0",  imem_req,  0);
      cyc(); #1;
      chk("bp_d1",    inst_data, 1);
      chk("bp_req1",  imem_req,  1);
      chk("bp_addr1", imem_addr, 16);
      cyc(); #1;
      chk("bp_p2",    inst_pc,   8);
      cyc(); #1;
      chk("bp_d3",    inst_data, 3);
      cyc(); #1;
      chk("bp_p4",    inst_pc,   16);

      // unconditional redirect, negative offset, with pop
      cyc();
      redir(1'b1, 64'h100, 32'hABFF_FFFC);
      #1;
      chk("unc_req_r", imem_req, 0);
      cyc();
      redir_valid = 1'b0;
      #1;
      chk("unc_val1",  inst_valid, 0);
      chk("unc_req1",  imem_req,   1);
      chk("unc_addr1", imem_addr,  64'hF0);
      cyc(); #1;
      chk("unc_val2",  inst_valid, 0);
      cyc(); #1;
      chk("unc_val3",  inst_valid, 1);
      chk("unc_pc3",   inst_pc,    64'hF0);
      chk("unc_data3", inst_data,  32'h3C);
      cyc(); #1;
      chk("unc_pc4",   inst_pc,    64'hF4);

      // conditional redirect with noise outside the field
      cyc();
      redir(1'b0, 64'h40, 32'hFF00_00BF);
      cyc();
      redir_valid = 1'b0;
      cyc(); cyc(); #1;
      chk("cnd_val3",  inst_valid, 1);
      chk("cnd_pc3",   inst_pc,    64'h54);
      chk("cnd_data3", inst_data,  32'h15);
      cyc(); #1;
      chk("cnd_pc4",   inst_pc,    64'h58);

      // back-to-back redirects: the later one wins
      cyc();
      redir(1'b1, 64'h1000, 32'h10);
      cyc();
      redir(1'b1, 64'h200, 32'h8);
      cyc();
      redir_valid = 1'b0;
      #1;
      chk("b2b_addr", imem_addr, 64'h220);
      cyc(); cyc(); #1;
      chk("b2b_pc",   inst_pc,   64'h220);
      chk("b2b_data", inst_data, 32'h88);

      // reset with a nearly full FIFO and a response in flight
      cyc();
      rst        = 1'b1;
      inst_ready = 1'b0;
      cyc();
      rst = 1'b0;
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      rst        = 1'b0;
      inst_ready = 1'b1;
      #1;
      chk("rst_val",  inst_valid, 0);
      chk("rst_addr", imem_addr,  0);
      chk("rst_req",  imem_req,   1);
      cyc(); cyc(); #1;
      chk("rst_pc",   inst_pc,    0);
      chk("rst_data", inst_data,  0);
      chk("rst_v2",   inst_valid, 1);

      // random traffic: ready, redirects, occasional reset
      for (int i = 0; i < 2000; i++) begin
         int busy;
         cyc();
         busy         = ((i / 50) % 2 == 0) ? 90 : 20;
         inst_ready   = ($urandom_range(99) < busy);
         rst          = ($urandom_range(199) == 0);
         redir_valid  = ($urandom_range(99) < 6);
         redir_uncond = $urandom_range(1) == 1;
         redir_pc     = {$urandom, $urandom};
         if ($urandom_range(3) == 0) redir_pc = 64'(($urandom_range(63)) * 4);
         redir_instr  = $urandom;
      end
      cyc();
      rst         = 1'b0;
      redir_valid = 1'b0;
      repeat (4) cyc();

      // PC wrap from the top of the address space
      rst_w = 1'b0;
      #1;
      chk("wrap_req0",  req_w,  1);
      chk("wrap_addr0", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(); #1;
      chk("wrap_addr1", addr_w, 0);
      cyc(); #1;
      chk("wrap_addr2", addr_w,  4);
      chk("wrap_val2",  valid_w, 1);
      chk("wrap_pc2",   pc_w,    64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_data2", data_w,  32'hFFFF_FFFF);
      cyc(); #1;
      chk("wrap_pc3",   pc_w,    0);
      chk("wrap_data3", data_w,  0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-cycle PC/branch path.
- Owns the PC and issues requests to a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions and their PCs in a FIFO, handed to decode over a valid/ready handshake.
- Accepts branch redirects from the execute stage: target = branch PC + (sign-extended offset << 2). A redirect flushes wrong-path work.

Parameters:
- ADDR_W, 64, PC / memory address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, fetch FIFO entries (power of two, >= 2).
- UNCOND_OFS_W, 26, unconditional branch offset width; field instr[UNCOND_OFS_W-1:0].
- COND_OFS_W, 19, conditional branch offset width; field instr[COND_OFS_W+4:5].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address (current PC)
- imem_rdata  in  INSTR_W  instruction for the request issued the previous cycle
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  INSTR_W  head instruction
- inst_pc  out  ADDR_W  head instruction address
- redir_valid  in  1  branch resolved taken this cycle
- redir_uncond  in  1  1: use UNCOND field; 0: use COND field
- redir_pc  in  ADDR_W  PC of the branch instruction
- redir_instr  in  INSTR_W  branch instruction word

Behaviour:
- Reset: clk, rst synchronous active-high; reset is decided.
  - Reset values: pc=RESET_PC, FIFO empty, inflight=0, state=FETCH.
  - Output reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
  - rst asserted mid-operation discards FIFO contents and any in-flight response on the next edge.
- States: FETCH (issuing) and STALL (no credit). Redirect overrides either state.
- Credit rule: issue iff count + inflight < DEPTH and !redir_valid.
  - A pop in the same cycle does not add credit; the rule is conservative.
  - With credit: imem_req=1, imem_addr=pc; pc <= pc + INSTR_W/8; inflight <= 1.
  - Without credit: state=STALL, imem_req=0, pc holds.
- Response: the cycle after an issue, imem_rdata is written into the FIFO with the issued PC, unless squashed.
  - inst_valid rises the cycle after the write.
  - Fetch-to-decode latency is therefore 2 cycles.
- Pop: inst_valid & inst_ready removes the head.
  - A push and a pop in the same cycle keep count unchanged.
- Full: count==DEPTH means no push is ever attempted; credit guarantees this. Overflow is an assertion failure.
- Empty: inst_valid=0; inst_data and inst_pc hold their last values.
- Redirect (redir_valid=1):
  - target = redir_pc + (sext(offset) << 2), computed modulo 2^ADDR_W. Wrap-around is legal and not flagged.
  - offset = redir_instr[UNCOND_OFS_W-1:0] when redir_uncond, else redir_instr[COND_OFS_W+4:5].
  - Next edge: pc <= target, FIFO cleared, inflight response marked squashed; its data next cycle is dropped.
  - No request is issued in the redirect cycle. The target is issued the following cycle, so the first target instruction reaches inst_valid 3 cycles after redir_valid.
  - Redirect and pop in the same cycle: redirect wins; inst_valid=0 next cycle.
  - Back-to-back redirects: the last one wins.
- Width rule: the PC increment uses the full ADDR_W with natural wrap.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t {instr, pc}
  - localparam INSTR_BYTES
  - function sext_ofs
- Sub-module fetch_fifo: parameterised DEPTH / entry type.
  - Ports: push, pop, clear, count, head.
  - Synchronous clear; registered head visibility (write to valid in 1 cycle).

Test Plan:
- Reset, inst_ready=1, memory word k=k at address 4k -> imem_addr sequence 0,4,8,...; first inst_valid 2 cycles after rst falls; inst_pc=0,4,8 with inst_data 0,1,2.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, imem_req=0 (STALL). Raise ready -> in-order 0..3 at one per cycle, fetch resumes at pc=16.
- Unconditional redirect: redir_pc=0x100, instr[25:0]=26'h3FFFFFC (-4) -> target 0x0F0; FIFO flushed, squashed response dropped, first inst_pc=0x0F0 3 cycles later.
- Conditional redirect: redir_pc=0x40, instr[23:5]=19'd5 -> target 0x54; no stale PCs appear after the redirect.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> fetch sequence ...FFFC then 0.
- rst asserted with a full FIFO and a response in flight -> next cycle inst_valid=0, imem_addr=RESET_PC; the old response never appears.
